controle_busca: RTL
===================

# controle_busca

Instruction-fetch controller that sequences the combinational-read instruction memory (`MemoriaInstrucao`) for the RISC-V core. It holds the PC, issues one word address per cycle and buffers fetched words in a 2-entry prefetch queue. It hands `{pc, instr}` pairs to decode over a valid/ready handshake. It also handles start, halt and branch/jump redirects, with a queue flush on redirect.

## Interface
- `BITS`, 32, instruction width
- `DEPTH`, 2000, number of instruction-memory words
- `I_ADDR_BITS`, 6, PC is `I_ADDR_BITS+1` bits (byte address); memory word address is `pc[I_ADDR_BITS:2]`
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: pulse; load `start_pc` and begin fetching (accepted in IDLE/HALT only)
- `start_pc` in I_ADDR_BITS+1: initial PC
- `halt` in 1: level; stop issuing fetches
- `redir_valid` in 1: pulse; branch/jump taken
- `redir_pc` in I_ADDR_BITS+1: redirect target
- `imem_addr` out I_ADDR_BITS-1: word address to instruction memory, equals `pc[I_ADDR_BITS:2]`
- `imem_dout` in BITS: instruction memory read data, same-cycle
- `inst_valid` out 1: queue head valid
- `inst_ready` in 1: decode accepts head
- `inst` out BITS: head instruction
- `inst_pc` out I_ADDR_BITS+1: head PC
- `busy` out 1: state is RUN
- `fault` out 1: sticky fetch fault (only with macro)

## Operation
- FSM states: IDLE, RUN, HALT, FAULT. Reset → IDLE.
- IDLE/HALT + `start`: `pc<=start_pc`, queue flushed, → RUN.
- RUN + `halt`: → HALT; no further pushes; queue keeps draining to decode.
- Fetch (RUN, not halted, no redirect this cycle): push `{pc, imem_dout}` when `!full || pop`; `pc<=pc+4`, wrapping modulo 2^(I_ADDR_BITS+1). Full with no pop: no push, pc held.
- Pop: `inst_valid && inst_ready`.
- Redirect (RUN only; ignored elsewhere): flush queue, discard any pop and push of that cycle, `pc<=redir_pc`. Redirect has priority over halt in the same cycle: pc is loaded, then → HALT.
- `start` in RUN or FAULT is ignored. FAULT exits only via `rst`.
- Queue: 2 entries, head/tail pointers plus count. `inst`/`inst_pc` show the head; they are zero when empty.

## Timing
- Reset values:
  - `pc=0`, `imem_addr=0`, queue empty
  - `inst_valid=0`, `inst=0`, `inst_pc=0`
  - `busy=0`, `fault=0`
- `start` at cycle t → `imem_addr=start_pc` word during t+1 → `inst_valid=1` at t+2.
- Redirect at t → `inst_valid=0` at t+1 → target instruction valid at t+2.
- Throughput: 1 instruction/cycle with `inst_ready` held high.
- `inst_ready` low for k cycles: queue fills after 2 pushes, then pc stalls; no instruction is lost or duplicated.
- `rst` mid-operation: immediate return to reset values, independent of clk.

## Configuration
- `FETCH_BOUND_CHK_EN` defined:
  - Fetch at word address ≥ `DEPTH`, or `start_pc`/`redir_pc` with nonzero bits [1:0], → FAULT.
  - The bad address is never pushed; `fault=1` from the next cycle until reset; earlier queued entries still drain.
- Undefined:
  - Bits [1:0] of loaded PCs are forced to 0.
  - Out-of-range word addresses are presented to memory unchanged.
  - `fault` is tied 0 and the FAULT state is unreachable.

## Structure
- Shared package `busca_pkg`: FSM state enum (IDLE, RUN, HALT, FAULT), constant `PC_INC=4`, queue-entry struct `{pc, instr}`.
- One sub-module: `fila_busca`, a 2-entry synchronous FIFO with flush, push, pop, full and empty.
- FSM and PC logic stay in `controle_busca`.

## Test plan
- Reset, `start` with `start_pc=0`, `inst_ready=1`, memory words 0..3 preloaded → `inst_pc` 0,4,8,12 on consecutive cycles starting 2 cycles after start; `inst` matches memory[0..3].
- `inst_ready=0` for 5 cycles after first valid → `imem_addr` holds after 2 pushes; on release, PCs continue 0,4,8 with no gaps or repeats.
- Redirect to 0x20 while the queue holds PCs 4 and 8 → next cycle `inst_valid=0`; following cycle `inst_pc=0x20`.
- `halt` asserted in RUN with a full queue → both entries delivered, then `inst_valid=0`; `start` with `start_pc=0x10` → `inst_pc=0x10` two cycles later.
- PC at the maximum aligned address with the macro undefined → next fetch PC is 0 (wrap).
- With `FETCH_BOUND_CHK_EN`, `redir_pc=0x06` → `fault=1` next cycle, `busy=0`, no new entries; `rst` clears `fault`.

Source files
------------

// File: rtl/busca_pkg.sv
// Shared types for the instruction-fetch controller.
// FSM state encoding, PC increment and the prefetch entry layout.
package busca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned DEF_BITS = 32;
  localparam int unsigned DEF_PC_W = 7;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic [DEF_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fila_busca.sv
// Two-entry prefetch FIFO with flush; head reads as zero when empty.
// Push while full is accepted only when a pop frees the slot the same cycle.
module fila_busca
  import busca_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  entry_t     mem_q [2];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full    = cnt_q == 2'd2;
  assign empty   = cnt_q == 2'd0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[head_q];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (do_push) tail_d = !tail_q;
      if (do_pop)  head_d = !head_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (do_push && !flush) mem_q[tail_q] <= din;
    end
  end

endmodule

// File: rtl/controle_busca.sv
// Fetch controller: PC, IDLE/RUN/HALT/FAULT FSM, prefetch queue to decode.
// FETCH_BOUND_CHK_EN enables the misaligned/out-of-range FAULT path.
module controle_busca
  import busca_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int DEPTH       = 2000,
  parameter int I_ADDR_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [I_ADDR_BITS:0]   start_pc,
  input  logic                   halt,
  input  logic                   redir_valid,
  input  logic [I_ADDR_BITS:0]   redir_pc,
  output logic [I_ADDR_BITS-2:0] imem_addr,
  input  logic [BITS-1:0]        imem_dout,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [BITS-1:0]        inst,
  output logic [I_ADDR_BITS:0]   inst_pc,
  output logic                   busy,
  output logic                   fault
);

  typedef logic [I_ADDR_BITS:0] pc_t;

  typedef struct packed {
    pc_t             pc;
    logic [BITS-1:0] instr;
  } ent_t;

  state_t state_q, state_d;
  pc_t    pc_q, pc_d;
  pc_t    load_raw, load_pc;
  logic   bad_load, bad_fetch;
  logic   q_full, q_empty;
  logic   q_push, q_pop, q_flush;
  ent_t   q_din, q_dout;

  // Same mux serves both load sources: only IDLE/HALT take start_pc
  assign load_raw = (state_q == RUN) ? redir_pc : start_pc;

`ifdef FETCH_BOUND_CHK_EN
  assign load_pc   = load_raw;
  assign bad_load  = |load_raw[1:0];
  assign bad_fetch =
    32'(pc_q[I_ADDR_BITS:2]) >= $unsigned(DEPTH);
  assign fault     = state_q == FAULT;
`else
  logic unused_cfg;
  assign load_pc    = {load_raw[I_ADDR_BITS:2], 2'b00};
  assign bad_load   = 1'b0;
  assign bad_fetch  = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = ^{load_raw[1:0], DEPTH > 0};
`endif

  assign imem_addr  = pc_q[I_ADDR_BITS:2];
  assign busy       = state_q == RUN;
  assign inst_valid = !q_empty;
  assign inst       = q_dout.instr;
  assign inst_pc    = q_dout.pc;
  assign q_pop      = inst_valid && inst_ready;
  assign q_din      = '{pc: pc_q, instr: imem_dout};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          q_flush = 1'b1;
          if (bad_load) begin
            state_d = FAULT;
          end else begin
            pc_d    = load_pc;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (redir_valid) begin
          q_flush = 1'b1;
          if (bad_load) begin
            state_d = FAULT;
          end else begin
            pc_d    = load_pc;
            state_d = halt ? HALT : RUN;
          end
        end else if (halt) begin
          state_d = HALT;
        end else if (bad_fetch) begin
          state_d = FAULT;
        end else if (!q_full || q_pop) begin
          q_push = 1'b1;
          pc_d   = pc_q + pc_t'(PC_INC);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fila_busca #(
    .entry_t(ent_t)
  ) u_fila (
    .clk  (clk),
    .rst  (rst),
    .flush(q_flush),
    .push (q_push),
    .pop  (q_pop),
    .din  (q_din),
    .dout (q_dout),
    .full (q_full),
    .empty(q_empty)
  );

endmodule
